// File: rtl/my_mux8way_arb.sv
// Eight-channel valid/ready collector onto one registered output, tagging each word with its source index.
// Define MY_MUX8WAY_ARB_RR_EN for round-robin arbitration; default build is fixed priority (lowest index wins).
module my_mux8way_arb #(
   parameter int unsigned WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           in_valid,
   input  logic [8*WIDTH-1:0]   in_data,
   output logic [7:0]           in_ready,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic [2:0]           out_sel,
   input  logic                 out_ready
);

   localparam int unsigned NCH  = 8;
   localparam int unsigned SELW = 3;

   logic                w_slot_free;
   logic                w_any_valid;
   logic                w_grant;
   logic [SELW-1:0]     w_win;
   logic [WIDTH-1:0]    w_win_data;

   logic                r_out_valid;
   logic [WIDTH-1:0]    r_out_data;
   logic [SELW-1:0]     r_out_sel;

   assign w_slot_free = !r_out_valid || out_ready;
   assign w_any_valid = |in_valid;
   assign w_grant     = w_slot_free && w_any_valid;

`ifdef MY_MUX8WAY_ARB_RR_EN
   logic [SELW-1:0]     r_ptr;
   logic [SELW-1:0]     w_idx;

   // Scan ptr..ptr+7 in reverse so the earliest valid position in scan order is the last assignment.
   always_comb begin
      w_win = r_ptr;
      w_idx = r_ptr;
      for (int k = 7; k >= 0; k--) begin
         w_idx = r_ptr + SELW'(k);
         if (in_valid[w_idx]) begin
            w_win = w_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (w_grant) begin
         r_ptr <= w_win + SELW'(1);
      end
   end
`else
   // Fixed priority: lowest set index wins.
   always_comb begin
      w_win = '0;
      for (int k = 7; k >= 0; k--) begin
         if (in_valid[k]) begin
            w_win = SELW'(k);
         end
      end
   end
`endif

   always_comb begin
      w_win_data = '0;
      for (int k = 0; k < int'(NCH); k++) begin
         if (w_win == SELW'(k)) begin
            w_win_data = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   // Grant is held off while reset is asserted so no source sees an acceptance during reset.
   always_comb begin
      in_ready = '0;
      if (rst_n && w_grant) begin
         in_ready[w_win] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= '0;
      end else if (w_grant) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_win_data;
         r_out_sel   <= w_win;
      end else if (w_slot_free) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_my_mux8way_arb.sv
// Directed-vector and scoreboard bench for my_mux8way_arb; expectations follow MY_MUX8WAY_ARB_RR_EN.
module tb_my_mux8way_arb;

   localparam int unsigned W = 16;
`ifdef MY_MUX8WAY_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic [7:0]        in_valid;
   logic [8*W-1:0]    in_data;
   logic [7:0]        in_ready;
   logic              out_valid;
   logic [W-1:0]      out_data;
   logic [2:0]        out_sel;
   logic              out_ready;

   my_mux8way_arb #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         rst;
      logic [7:0] v;
      logic       ordy;
      logic [7:0] exp_rdy;
      logic       exp_ov;
      logic [2:0] exp_sel;
   } vec_t;

   typedef struct packed {
      logic [2:0]  s;
      logic [15:0] d;
   } exp_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   vec_t        vecs[$];
   logic [15:0] cd [8];
   exp_t        q[$];
   exp_t        e;
   int          seq [8];
   logic [7:0]  acc;
   int          received;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(bit rst, logic [7:0] v, logic ordy, logic [7:0] er, logic eov, logic [2:0] es);
      vec_t r;
      r.rst = rst; r.v = v; r.ordy = ordy; r.exp_rdy = er; r.exp_ov = eov; r.exp_sel = es;
      return r;
   endfunction

   initial begin
      cd[0] = 16'hC0A0; cd[1] = 16'hC1A1; cd[2] = 16'hC2A2; cd[3] = 16'hBEEF;
      cd[4] = 16'hC4A4; cd[5] = 16'hC5A5; cd[6] = 16'hC6A6; cd[7] = 16'hC7A7;
      for (int i = 0; i < 8; i++) in_data[i*W +: W] = cd[i];

      // Single source after reset, then idle
      vecs.push_back(mk(1, 8'h08, 1, 8'h08, 1, 3'd3));
      vecs.push_back(mk(0, 8'h00, 1, 8'h00, 0, 3'd3));
      // All eight valid from a fresh reset
      for (int k = 0; k < 9; k++)
         vecs.push_back(mk(k == 0, 8'hFF, 1, RR ? 8'(8'h01 << (k % 8)) : 8'h01, 1, RR ? 3'(k % 8) : 3'd0));
      // Wrap-around: grant 7, then 0 and 7 compete, then all valid reveals ptr
      vecs.push_back(mk(0, 8'h80, 1, 8'h80, 1, 3'd7));
      vecs.push_back(mk(0, 8'h81, 1, 8'h01, 1, 3'd0));
      vecs.push_back(mk(0, 8'hFF, 1, RR ? 8'h02 : 8'h01, 1, RR ? 3'd1 : 3'd0));
      // Backpressure with channel 5 in the slot
      vecs.push_back(mk(0, 8'h20, 1, 8'h20, 1, 3'd5));
      for (int k = 0; k < 4; k++)
         vecs.push_back(mk(0, 8'hFF, 0, 8'h00, 1, 3'd5));
      vecs.push_back(mk(0, 8'hFF, 1, RR ? 8'h40 : 8'h01, 1, RR ? 3'd6 : 3'd0));

      // Reset state, with every source requesting
      rst_n = 1'b0; in_valid = 8'hFF; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_out_sel", 32'(out_sel), 32'h0);

      foreach (vecs[n]) begin
         if (vecs[n].rst) begin
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
         end
         in_valid  = vecs[n].v;
         out_ready = vecs[n].ordy;
         #1;
         chk($sformatf("vec%0d_in_ready", n), 32'(in_ready), 32'(vecs[n].exp_rdy));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_out_valid", n), 32'(out_valid), 32'(vecs[n].exp_ov));
         chk($sformatf("vec%0d_out_sel", n), 32'(out_sel), 32'(vecs[n].exp_sel));
         chk($sformatf("vec%0d_out_data", n), 32'(out_data), 32'(cd[vecs[n].exp_sel]));
      end

      // Asynchronous reset while the slot is full
      in_valid = 8'hFF; out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'h0);
      chk("arst_in_ready", 32'(in_ready), 32'h0);
      chk("arst_out_data", 32'(out_data), 32'h0);
      chk("arst_out_sel", 32'(out_sel), 32'h0);
      @(posedge clk);
      #1;
      chk("arst_hold_valid", 32'(out_valid), 32'h0);
      #2;
      rst_n = 1'b1; in_valid = 8'h06; out_ready = 1'b1;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'h02);
      @(posedge clk);
      #1;
      chk("post_rst_out_valid", 32'(out_valid), 32'h1);
      chk("post_rst_out_sel", 32'(out_sel), 32'h1);
      chk("post_rst_out_data", 32'(out_data), 32'(cd[1]));
      in_valid = 8'h00;
      @(posedge clk);
      #1;
      chk("drain_out_valid", 32'(out_valid), 32'h0);

      // Round-trip: random sources, random consumer, demux-by-out_sel scoreboard
      received = 0;
      for (int i = 0; i < 8; i++) seq[i] = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < 8; i++) begin
            if (!in_valid[i] && cyc < 350 && $urandom_range(0, 2) == 0) begin
               in_valid[i] = 1'b1;
               in_data[i*W +: W] = {3'(i), 13'(seq[i])};
               seq[i]++;
            end
         end
         out_ready = (cyc >= 350) ? 1'b1 : ($urandom_range(0, 3) != 0);
         #3;
         chk("rt_ready_onehot", 32'($onehot0(in_ready)), 32'h1);
         chk("rt_ready_subset", 32'(in_ready & ~in_valid), 32'h0);
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("rt_unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
               e = q.pop_front();
               chk("rt_out_sel", 32'(out_sel), 32'(e.s));
               chk("rt_out_data", 32'(out_data), 32'(e.d));
               received++;
            end
         end
         acc = in_ready & in_valid;
         for (int i = 0; i < 8; i++)
            if (acc[i]) q.push_back({3'(i), in_data[i*W +: W]});
         @(posedge clk);
         #1;
         in_valid = in_valid & ~acc;
      end
      chk("rt_pending_sources", 32'(in_valid), 32'h0);
      chk("rt_scoreboard_empty", 32'(q.size()), 32'h0);
      chk("rt_words_received", 32'(received > 100), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
